// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: block-RAM sweep sequencer that fills every word with a pattern or reads it back and counts mismatches.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, op, pat_mode,  command strobe, 0=FILL/1=CHECK, pattern select and seed;
//   seed                  all captured only on a start accepted in IDLE
//   abort                 ends an active sweep without a done pulse
//   busy, done            sweep in progress / one-cycle completion pulse
//   err_count             saturating CHECK mismatch count
//   mem_raddr, mem_waddr, memory port drive (addresses zero-extended to 32 bits)
//   mem_we, mem_din
//   mem_dout              memory read data, one cycle after mem_raddr
//
// Optional build macro MEM_SWEEP_FIRST_FAIL_EN adds first_fail_valid/addr/data,
// holding the address and read data of the first CHECK mismatch since the last
// CHECK start.
module mem_sweep_ctrl #(
   parameter int WID_MEM   = 16,
   parameter int DEPTH_MEM = 16384,
   parameter int ERR_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op,
   input  logic [1:0]         pat_mode,
   input  logic [WID_MEM-1:0] seed,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [ERR_W-1:0]   err_count,
   output logic [31:0]        mem_raddr,
   output logic [31:0]        mem_waddr,
   output logic               mem_we,
   output logic [WID_MEM-1:0] mem_din,
   input  logic [WID_MEM-1:0] mem_dout
`ifdef MEM_SWEEP_FIRST_FAIL_EN
   ,
   output logic               first_fail_valid,
   output logic [31:0]        first_fail_addr,
   output logic [WID_MEM-1:0] first_fail_data
`endif
);
   localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
   localparam int XW = (WID_MEM > AW) ? WID_MEM : AW;
   localparam logic [AW-1:0] LAST = AW'(DEPTH_MEM - 1);
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FILL     = 3'd1;
   localparam logic [2:0] S_CHK_RD   = 3'd2;
   localparam logic [2:0] S_CHK_LAST = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]         state;
   logic [AW-1:0]      a;
   logic [1:0]         pat_r;
   logic [WID_MEM-1:0] seed_r, exp_r, pat_a;
   logic               vld_r, miss;

   // The address is widened before slicing so narrow counters zero-extend
   // and wide counters truncate to the word width.
   function automatic logic [WID_MEM-1:0] pat(input logic [1:0] m, input logic [WID_MEM-1:0] s,
                                              input logic [AW-1:0] ad);
      logic [XW-1:0] ax;
      ax = XW'(ad);
      return m == 2'd0 ? s :
             m == 2'd1 ? ax[WID_MEM-1:0] ^ s :
             m == 2'd2 ? ~ax[WID_MEM-1:0] ^ s :
             ad[0] ? ~s : s;
   endfunction

   assign pat_a     = pat(pat_r, seed_r, a);
   assign busy      = state == S_FILL || state == S_CHK_RD || state == S_CHK_LAST;
   assign done      = state == S_DONE;
   assign mem_we    = state == S_FILL;
   assign mem_din   = mem_we ? pat_a : '0;
   assign mem_waddr = 32'(a);
   assign mem_raddr = 32'(a);
   // vld_r is only ever set by a CHK_RD cycle that was not aborted, so it
   // alone qualifies the compare of the word read on the previous cycle.
   assign miss      = vld_r && mem_dout != exp_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         a         <= '0;
         pat_r     <= '0;
         seed_r    <= '0;
         exp_r     <= '0;
         vld_r     <= 1'b0;
         err_count <= '0;
      end else begin
         vld_r <= state == S_CHK_RD && !abort;
         exp_r <= pat_a;
         if (miss && err_count != '1) err_count <= err_count + ERR_W'(1);
         case (state)
            S_IDLE: if (start) begin
               a      <= '0;
               pat_r  <= pat_mode;
               seed_r <= seed;
               state  <= op ? S_CHK_RD : S_FILL;
               if (op) err_count <= '0;
            end
            S_FILL: begin
               if (abort) state <= S_IDLE;
               else if (a == LAST) state <= S_DONE;
               else a <= a + AW'(1);
            end
            S_CHK_RD: begin
               if (abort) state <= S_IDLE;
               else if (a == LAST) state <= S_CHK_LAST;
               else a <= a + AW'(1);
            end
            S_CHK_LAST: state <= abort ? S_IDLE : S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_SWEEP_FIRST_FAIL_EN
   logic [AW-1:0] addr_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r           <= '0;
         first_fail_valid <= 1'b0;
         first_fail_addr  <= '0;
         first_fail_data  <= '0;
      end else begin
         addr_r <= a;
         if (state == S_IDLE && start && op) begin
            first_fail_valid <= 1'b0;
            first_fail_addr  <= '0;
            first_fail_data  <= '0;
         end else if (miss && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_addr  <= 32'(addr_r);
            first_fail_data  <= mem_dout;
         end
      end
   end
`endif
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: directed bench with a cycle-indexed sweep model and behavioural RAM for mem_sweep_ctrl.
module tb_mem_sweep_ctrl;
   localparam int D = 16;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0, abort = 1'b0;
   logic [1:0]  pat_mode = 2'd0;
   logic [15:0] seed = 16'h0;
   logic        busy, done, mem_we;
   logic [1:0]  err_count;
   logic [31:0] mem_raddr, mem_waddr;
   logic [15:0] mem_din, mem_dout = 16'h0;
`ifdef MEM_SWEEP_FIRST_FAIL_EN
   logic        first_fail_valid;
   logic [31:0] first_fail_addr;
   logic [15:0] first_fail_data;
`endif

   mem_sweep_ctrl #(.WID_MEM(16), .DEPTH_MEM(D), .ERR_W(2)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .pat_mode(pat_mode), .seed(seed),
      .abort(abort), .busy(busy), .done(done), .err_count(err_count),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_din(mem_din),
      .mem_dout(mem_dout)
`ifdef MEM_SWEEP_FIRST_FAIL_EN
      , .first_fail_valid(first_fail_valid), .first_fail_addr(first_fail_addr),
      .first_fail_data(first_fail_data)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] ram [D];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_a = 4'd0;
   always @(posedge clk) begin
      if (mem_we) ram[mem_waddr[3:0]] <= mem_din;
      if (poke_en) ram[poke_a] <= ram[poke_a] ^ 16'h0001;
      mem_dout <= ram[mem_raddr[3:0]];
   end

   int total = 0, passes = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [15:0] p(input logic [1:0] m, input logic [15:0] s, input int ad);
      case (m)
         2'd0:    return s;
         2'd1:    return 16'(ad) ^ s;
         2'd2:    return ~16'(ad) ^ s;
         default: return (ad % 2 == 1) ? ~s : s;
      endcase
   endfunction

   // Sweep model: a sweep accepted in cycle t0 is described purely by the
   // elapsed cycle count k = cyc - t0 and the cycle an abort was honoured.
   int          t0 = -1, ab = -1;
   logic        m_op = 1'b0;
   logic [1:0]  m_pat = 2'd0;
   logic [15:0] m_seed = 16'h0;

   function automatic int end_k();
      return m_op ? D + 2 : D + 1;
   endfunction
   function automatic logic exp_busy(input int c);
      return t0 >= 0 && c - t0 >= 1 && c - t0 < end_k() && (ab < 0 || c <= ab);
   endfunction
   function automatic logic exp_done(input int c);
      return t0 >= 0 && ab < 0 && c - t0 == end_k();
   endfunction
   function automatic int model_err();
      int n = 0;
      for (int i = 0; i < D; i++) if (ram[i] !== p(m_pat, m_seed, i)) n++;
      return n > 3 ? 3 : n;
   endfunction
   function automatic int first_bad();
      for (int i = 0; i < D; i++) if (ram[i] !== p(m_pat, m_seed, i)) return i;
      return -1;
   endfunction

   int   wr_cnt = 0, done_cnt = 0, k = 0;
   logic eb, ed, ew;
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_we", 32'(mem_we), 0);
         chk("rst_err", 32'(err_count), 0);
         chk("rst_raddr", mem_raddr, 0);
         chk("rst_waddr", mem_waddr, 0);
         chk("rst_din", 32'(mem_din), 0);
         t0 = -1;
         ab = -1;
      end else begin
         k  = cyc - t0;
         eb = exp_busy(cyc);
         ed = exp_done(cyc);
         ew = eb && !m_op;
         chk("busy", 32'(busy), 32'(eb));
         chk("done", 32'(done), 32'(ed));
         chk("mem_we", 32'(mem_we), 32'(ew));
         if (ew) begin
            chk("waddr", mem_waddr, 32'(k - 1));
            chk("din", 32'(mem_din), 32'(p(m_pat, m_seed, k - 1)));
         end
         if (eb && m_op && k <= D) chk("raddr", mem_raddr, 32'(k - 1));
         if (ed && m_op) begin
            chk("err_count", 32'(err_count), 32'(model_err()));
`ifdef MEM_SWEEP_FIRST_FAIL_EN
            chk("ff_valid", 32'(first_fail_valid), 32'(first_bad() >= 0));
            if (first_bad() >= 0) begin
               chk("ff_addr", first_fail_addr, 32'(first_bad()));
               chk("ff_data", 32'(first_fail_data), 32'(ram[first_bad()]));
            end
`endif
         end
         if (mem_we) wr_cnt++;
         if (done) done_cnt++;
         if (start && !eb && !ed) begin
            t0 = cyc;
            ab = -1;
            m_op = op;
            m_pat = pat_mode;
            m_seed = seed;
         end else if (abort && eb) ab = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int ts = 0, td = 0;
   task automatic start_op(input logic o, input logic [1:0] m, input logic [15:0] s);
      start = 1'b1;
      op = o;
      pat_mode = m;
      seed = s;
      ts = cyc;
      tick();
      start = 1'b0;
      op = ~o;
      pat_mode = ~m;
      seed = ~s;
   endtask

   task automatic wait_done(input string name);
      logic got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            td = cyc;
         end
      end
      chk(name, 32'(got), 1);
      tick();
   endtask

   task automatic poke(input logic [3:0] ad);
      poke_en = 1'b1;
      poke_a = ad;
      tick();
      poke_en = 1'b0;
   endtask

   int w0 = 0, d0 = 0;
   initial begin
      repeat (2) tick();
      chk("rst_err_lit", 32'(err_count), 0);
      chk("rst_busy_lit", 32'(busy), 0);
      reset = 1'b0;
      tick();
      // FILL pattern 0
      w0 = wr_cnt;
      start_op(1'b0, 2'd0, 16'hA5A5);
      wait_done("fill0_done");
      chk("fill0_lat", 32'(td - ts), 17);
      chk("fill0_writes", 32'(wr_cnt - w0), 16);
      chk("fill0_ram0", 32'(ram[0]), 32'h0000A5A5);
      chk("fill0_ram15", 32'(ram[15]), 32'h0000A5A5);
      // FILL then CHECK pattern 1
      start_op(1'b0, 2'd1, 16'h00FF);
      wait_done("fill1_done");
      chk("fill1_ram3", 32'(ram[3]), 32'h000000FC);
      start_op(1'b1, 2'd1, 16'h00FF);
      wait_done("chk1_done");
      chk("chk1_lat", 32'(td - ts), 18);
      chk("chk1_err_lit", 32'(err_count), 0);
      // CHECK pattern 3 with two corrupted words
      start_op(1'b0, 2'd3, 16'h0F0F);
      wait_done("fill3_done");
      poke(4'd3);
      poke(4'd15);
      start_op(1'b1, 2'd3, 16'h0F0F);
      wait_done("chk3_done");
      chk("chk3_err_lit", 32'(err_count), 2);
`ifdef MEM_SWEEP_FIRST_FAIL_EN
      chk("chk3_ff_addr_lit", first_fail_addr, 3);
      chk("chk3_ff_data_lit", 32'(first_fail_data), 32'h0000F0F1);
`endif
      // all words wrong: 2-bit counter saturates
      start_op(1'b1, 2'd0, 16'h1234);
      wait_done("chk_sat_done");
      chk("chk_sat_err_lit", 32'(err_count), 3);
      // abort on the 5th FILL cycle, then immediate restart
      w0 = wr_cnt;
      d0 = done_cnt;
      start_op(1'b0, 2'd2, 16'h0000);
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_writes", 32'(wr_cnt - w0), 5);
      chk("abort_no_done", 32'(done_cnt - d0), 0);
      w0 = wr_cnt;
      start_op(1'b0, 2'd2, 16'h0000);
      wait_done("restart_done");
      chk("restart_writes", 32'(wr_cnt - w0), 16);
      chk("fill2_ram2", 32'(ram[2]), 32'h0000FFFD);
      // asynchronous reset in the middle of a mismatching CHECK
      start_op(1'b1, 2'd0, 16'h1234);
      repeat (6) tick();
      chk("pre_rst_err", 32'(err_count), 3);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_err", 32'(err_count), 0);
      chk("arst_raddr", mem_raddr, 0);
      chk("arst_waddr", mem_waddr, 0);
      chk("arst_we", 32'(mem_we), 0);
      chk("arst_done", 32'(done), 0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("no_resume", 32'(busy), 0);
      // start held high for the whole sweep
      d0 = done_cnt;
      start = 1'b1;
      op = 1'b0;
      pat_mode = 2'd0;
      seed = 16'h1111;
      ts = cyc;
      wait_done("held_done");
      start = 1'b0;
      chk("held_lat", 32'(td - ts), 17);
      repeat (3) tick();
      chk("held_single_done", 32'(done_cnt - d0), 1);
      chk("held_idle", 32'(busy), 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
- Sequencer that owns the write/read ports of one block-RAM memory instance and sweeps every address.
- FILL writes a generated pattern to every address; CHECK reads every address back, compares against the same pattern and counts mismatches.
- Used to initialise and verify RAM contents before and after bitstream reinit experiments. Sits between the test top-level and the write-enabled memory instance.

Parameters:
- WID_MEM, 16, data width of the memory word
- DEPTH_MEM, 16384, number of words; sweep covers addresses 0..DEPTH_MEM-1; need not be a power of two
- ERR_W, 32, width of the mismatch counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  one-cycle command strobe; sampled only in IDLE
- op  in  1  0 = FILL, 1 = CHECK; sampled with start
- pat_mode  in  2  pattern select; sampled with start
- seed  in  WID_MEM  pattern seed; sampled with start
- abort  in  1  terminates an active sweep
- busy  out  1  high from the cycle after an accepted start until the sweep completes or aborts
- done  out  1  one-cycle pulse on normal completion
- err_count  out  ERR_W  CHECK mismatch count; saturating
- mem_raddr  out  32  memory read address, zero-extended
- mem_waddr  out  32  memory write address, zero-extended
- mem_we  out  1  memory write enable; the memory instance honours it
- mem_din  out  WID_MEM  memory write data
- mem_dout  in  WID_MEM  memory read data; valid one cycle after mem_raddr

Behaviour:
- Reset values: busy=0, done=0, err_count=0, mem_raddr=0, mem_waddr=0, mem_we=0, mem_din=0. Internal: state=IDLE, address counter=0.
- Start capture: start, op, pat_mode and seed are captured into registers on the accepted start. Changes to these inputs during a sweep have no effect. start while busy is ignored.
- Pattern P(a), for address a:
  - pat_mode 0: seed
  - pat_mode 1: a[WID_MEM-1:0] XOR seed; a is zero-extended if narrower than WID_MEM
  - pat_mode 2: ~a[WID_MEM-1:0] XOR seed
  - pat_mode 3: seed when a[0]=0, ~seed when a[0]=1
- States: IDLE, FILL, CHK_RD, CHK_LAST, DONE.
- IDLE:
  - mem_we=0.
  - start with op=0 goes to FILL.
  - start with op=1 clears err_count and goes to CHK_RD.
  - The address counter is 0 on entry to FILL or CHK_RD.
- FILL:
  - Each cycle: mem_we=1, mem_waddr=a, mem_din=P(a), a increments.
  - The cycle that writes a=DEPTH_MEM-1 is the last FILL cycle; the next state is DONE.
  - Exactly DEPTH_MEM write cycles; no write reaches any address >= DEPTH_MEM.
- CHK_RD:
  - Each cycle: mem_raddr=a. The expected value P(a) and a valid flag are registered for one cycle.
  - When the registered valid flag is set, mem_dout is compared with the registered expected value.
  - After issuing a=DEPTH_MEM-1, the next state is CHK_LAST.
  - mem_we=0 throughout CHECK.
- CHK_LAST: performs the final compare (no new read), then goes to DONE.
- err_count: increments by 1 per mismatching word and saturates at 2^ERR_W-1.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then the state returns to IDLE.
- Latency from the start cycle to the done pulse: FILL is DEPTH_MEM+1 cycles; CHECK is DEPTH_MEM+2 cycles.
- abort:
  - In FILL, CHK_RD or CHK_LAST, the next state is IDLE.
  - mem_we is 0 from the cycle after abort is sampled; no further compares.
  - done is not pulsed; err_count keeps its partial value.
  - abort in IDLE or DONE is ignored. If abort and start are asserted in the same IDLE cycle, start wins.
- Asynchronous reset mid-sweep: outputs go to reset values immediately; the sweep is not resumed.
- Address counter width: clog2(DEPTH_MEM). The comparison against DEPTH_MEM-1 is exact, so there is no wrap to 0 inside a sweep.

Optional Feature:
- Macro: MEM_SWEEP_FIRST_FAIL_EN.
- Defined:
  - Adds outputs first_fail_valid (1), first_fail_addr (32), first_fail_data (WID_MEM).
  - These capture the address and mem_dout of the first CHECK mismatch after a start.
  - All three clear on reset and on each accepted CHECK start. The capture holds through done and abort.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- FILL, pat_mode 0, seed=16'hA5A5, DEPTH_MEM=16 -> mem_we high for exactly 16 cycles, waddr 0..15, din=A5A5 each cycle; done one cycle after the last write.
- FILL then CHECK, pat_mode 1, seed=16'h00FF, backed by a behavioural RAM -> err_count=0, done 18 cycles after the CHECK start.
- CHECK pat_mode 3, seed=16'h0F0F, RAM corrupted at addresses 3 and 15 -> err_count=2; first_fail_addr=3 when MEM_SWEEP_FIRST_FAIL_EN is defined.
- ERR_W=2, CHECK over all-wrong contents -> err_count saturates at 3.
- abort asserted on the 5th FILL cycle -> no writes after it, busy low the next cycle, no done pulse; a new start on the next IDLE cycle is accepted.
- reset asserted mid-CHECK, asynchronous to the clock edge -> all outputs 0 immediately; start held during busy in a separate run -> ignored, single done only.
